nibble_demux_collect: RTL and testbench

//  1:2 nibble demultiplexer with per-destination collection, the inverse of the 4-bit 2:1 share mux.

---
 rtl/nibble_demux_collect_pkg.sv | 16 +
 rtl/nibble_demux_collect_bank.sv | 57 +++++
 rtl/nibble_demux_collect.sv | 61 ++++++
 tb/tb_nibble_demux_collect.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/nibble_demux_collect_pkg.sv
// ============================================================================
// Module  : nibble_demux_collect_pkg
// Brief   : Shared widths and bank-select encoding for the nibble demux/collector.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package nibble_demux_collect_pkg;
    localparam int NIBBLE_W = 4;
    localparam int STATE_W  = 64;

    localparam logic SEL_T = 1'b1;
    localparam logic SEL_F = 1'b0;
endpackage

`default_nettype wire

// File: rtl/nibble_demux_collect_bank.sv
// ============================================================================
// Module  : nibble_bank
// Brief   : One collector: packs NIBBLES nibbles LSB-first into a word and
//           presents it on a valid/ready handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_bank
    import nibble_demux_collect_pkg::*;
#(
    parameter int NIBBLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_en,
    input  logic [NIBBLE_W-1:0]          nib,
    output logic                         full,
    output logic                         valid,
    input  logic                         ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  data
);
    localparam int CNT_W = $clog2(NIBBLES);
    localparam logic [CNT_W-1:0] c_LAST_CNT = CNT_W'(NIBBLES - 1);

    logic [CNT_W-1:0]            r_cnt;
    logic                        r_full;
    logic [NIBBLE_W*NIBBLES-1:0] r_data;
    logic                        w_take;

    // A full bank never takes a nibble, even if the top misroutes wr_en.
    assign w_take = wr_en & ~r_full;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt  <= '0;
            r_full <= 1'b0;
            r_data <= '0;
        end else if (w_take) begin
            r_data[r_cnt*NIBBLE_W +: NIBBLE_W] <= nib;
            if (r_cnt == c_LAST_CNT) begin
                r_cnt  <= '0;
                r_full <= 1'b1;
            end else begin
                r_cnt  <= r_cnt + CNT_W'(1);
            end
        end else if (r_full && ready) begin
            r_full <= 1'b0;
        end
    end

    assign full  = r_full;
    assign valid = r_full;
    assign data  = r_data;
endmodule

`default_nettype wire

// File: rtl/nibble_demux_collect.sv
// ============================================================================
// Module  : nibble_demux_collect
// Brief   : 1:2 nibble demultiplexer steering a nibble stream into bank T or F.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module nibble_demux_collect
    import nibble_demux_collect_pkg::*;
#(
    parameter int NIBBLES = 16
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic                         sel,
    input  logic [NIBBLE_W-1:0]          nib,
    output logic                         t_valid,
    input  logic                         t_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  t_data,
    output logic                         f_valid,
    input  logic                         f_ready,
    output logic [NIBBLE_W*NIBBLES-1:0]  f_data
);
    logic w_t_full;
    logic w_f_full;
    logic w_accept;
    logic w_wr_t;
    logic w_wr_f;

    // Ready depends only on sel so a full bank never stalls traffic to the other.
    assign in_ready = (sel == SEL_T) ? ~w_t_full : ~w_f_full;
    assign w_accept = in_valid & in_ready;
    assign w_wr_t   = w_accept & (sel == SEL_T);
    assign w_wr_f   = w_accept & (sel == SEL_F);

    nibble_bank #(.NIBBLES(NIBBLES)) u_bank_t (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (w_wr_t),
        .nib   (nib),
        .full  (w_t_full),
        .valid (t_valid),
        .ready (t_ready),
        .data  (t_data)
    );

    nibble_bank #(.NIBBLES(NIBBLES)) u_bank_f (
        .clk   (clk),
        .rst_n (rst_n),
        .wr_en (w_wr_f),
        .nib   (nib),
        .full  (w_f_full),
        .valid (f_valid),
        .ready (f_ready),
        .data  (f_data)
    );
endmodule

`default_nettype wire

// File: tb/tb_nibble_demux_collect.sv
// ============================================================================
// Module  : tb_nibble_demux_collect
// Brief   : Directed self-checking bench for nibble_demux_collect (16 and 2 nibbles).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_nibble_demux_collect;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, sel;
    logic [3:0]  nib;
    logic        t_valid, t_ready, f_valid, f_ready;
    logic [63:0] t_data, f_data;

    logic        in_valid2, in_ready2, sel2;
    logic [3:0]  nib2;
    logic        t_valid2, t_ready2, f_valid2, f_ready2;
    logic [7:0]  t_data2, f_data2;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    nibble_demux_collect #(.NIBBLES(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .sel(sel), .nib(nib), .t_valid(t_valid), .t_ready(t_ready),
        .t_data(t_data), .f_valid(f_valid), .f_ready(f_ready), .f_data(f_data)
    );

    nibble_demux_collect #(.NIBBLES(2)) dut2 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .sel(sel2), .nib(nib2), .t_valid(t_valid2), .t_ready(t_ready2),
        .t_data(t_data2), .f_valid(f_valid2), .f_ready(f_ready2), .f_data(f_data2)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", tag, act, exp);
        end
    endtask

    // One valid cycle on the main instance; returns just after the edge.
    task automatic push(input logic s, input logic [3:0] n);
        in_valid = 1'b1;
        sel      = s;
        nib      = n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; sel = 1'b0; nib = 4'h0;
        t_ready = 1'b0; f_ready = 1'b0;
        in_valid2 = 1'b0; sel2 = 1'b0; nib2 = 4'h0; t_ready2 = 1'b0; f_ready2 = 1'b0;
        #12;
        check("rst_t_valid", 64'(t_valid), 64'd0);
        check("rst_f_valid", 64'(f_valid), 64'd0);
        check("rst_t_data",  t_data, 64'd0);
        check("rst_f_data",  f_data, 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_in_ready", 64'(in_ready), 64'd1);

        // 1: fill bank F with 0..F
        for (int i = 0; i < 16; i++) begin
            push(1'b0, 4'(i));
            if (i == 14) check("t1_f_valid_early", 64'(f_valid), 64'd0);
        end
        check("t1_f_valid", 64'(f_valid), 64'd1);
        check("t1_f_data",  f_data, 64'hFEDCBA9876543210);
        check("t1_t_valid", 64'(t_valid), 64'd0);

        // 2: hold while full, then drain
        in_valid = 1'b1; sel = 1'b0; nib = 4'h5;
        for (int i = 0; i < 10; i++) begin
            check("t2_hold_ready", 64'(in_ready), 64'd0);
            check("t2_hold_data",  f_data, 64'hFEDCBA9876543210);
            @(posedge clk); #1;
        end
        in_valid = 1'b0; f_ready = 1'b1;
        @(posedge clk); #1;
        f_ready = 1'b0;
        check("t2_drain_valid", 64'(f_valid), 64'd0);
        check("t2_drain_ready", 64'(in_ready), 64'd1);

        // 3: interleaved fill of both banks
        for (int n = 0; n < 32; n++) begin
            push((n % 2) == 0, 4'(n % 16));
            if (n == 30) check("t3_t_valid_31", 64'(t_valid), 64'd1);
        end
        check("t3_t_valid", 64'(t_valid), 64'd1);
        check("t3_f_valid", 64'(f_valid), 64'd1);
        check("t3_t_data",  t_data, 64'hECA86420ECA86420);
        check("t3_f_data",  f_data, 64'hFDB97531FDB97531);

        // 4: same-edge drain and input to full bank T: no bypass
        t_ready = 1'b1; in_valid = 1'b1; sel = 1'b1; nib = 4'h7;
        #1;
        check("t4_ready_blocked", 64'(in_ready), 64'd0);
        @(posedge clk); #1;
        t_ready = 1'b0;
        check("t4_drained",  64'(t_valid), 64'd0);
        check("t4_no_write", t_data, 64'hECA86420ECA86420);
        check("t4_ready_now", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("t4_accepted", t_data, 64'hECA86420ECA86427);
        check("t4_f_untouched", f_data, 64'hFDB97531FDB97531);

        // 5: asynchronous reset mid-fill, then refill with A
        for (int i = 0; i < 6; i++) push(1'b1, 4'h1);
        #2 rst_n = 1'b0;
        #1;
        check("t5_rst_t_data",  t_data, 64'd0);
        check("t5_rst_f_data",  f_data, 64'd0);
        check("t5_rst_f_valid", 64'(f_valid), 64'd0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 16; i++) begin
            push(1'b1, 4'hA);
            if (i == 14) check("t5_no_early_valid", 64'(t_valid), 64'd0);
        end
        check("t5_t_valid", 64'(t_valid), 64'd1);
        check("t5_t_data",  t_data, 64'hAAAAAAAAAAAAAAAA);

        // 6: NIBBLES=2 instance
        in_valid2 = 1'b1; sel2 = 1'b1; nib2 = 4'h3;
        @(posedge clk); #1;
        check("t6_valid_after1", 64'(t_valid2), 64'd0);
        nib2 = 4'hC;
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        check("t6_valid_after2", 64'(t_valid2), 64'd1);
        check("t6_t_data",       64'(t_data2), 64'hC3);
        check("t6_f_valid",      64'(f_valid2), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

`default_nettype wire
